prime_sequence_generator: RTL and testbench

Sequential producer of the ascending list of primes in the range 2 to 2^WIDTH-1. It is the generator counterpart of the team's combinational 4-bit prime detector. The detector answers "is a prime?", while this block walks the candidate range, tests each value by iterative trial division, and streams every prime found over a valid/ready interface. It is used as a self-checking stimulus source and as a standalone demo block on the lab board.

---
 rtl/prime_sequence_generator_if.sv | 36 +++
 rtl/prime_sequence_generator.sv | 142 ++++++++++++++
 tb/tb_prime_sequence_generator.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/prime_sequence_generator_if.sv
// Purpose : valid/ready streaming bundle of the prime sequence generator.
// Signals : start     - begin a new sweep (consumer -> generator)
//           out_ready - consumer accepts out_prime this cycle
//           out_valid - out_prime holds a prime awaiting acceptance
//           out_prime - current prime value, WIDTH bits
//           busy      - generator is testing or emitting
//           done      - one-cycle pulse after a sweep completes
// Modports: master = generator side, slave = consumer side.
interface prime_sequence_generator_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_prime;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    input  out_ready,
    output out_valid,
    output out_prime,
    output busy,
    output done
  );

  modport slave (
    output start,
    output out_ready,
    input  out_valid,
    input  out_prime,
    input  busy,
    input  done
  );
endinterface

// File: rtl/prime_sequence_generator.sv
// Purpose : walks candidates 2..2^WIDTH-1, tests each by iterative trial
//           division (one divisor per clock) and streams every prime found
//           over a valid/ready handshake.
// Ports   : clk - clock, rising edge
//           rst - asynchronous, active-high reset
//           bus - prime_sequence_generator_if.master (start, out_ready in;
//                 out_valid, out_prime, busy, done out, all registered)
module prime_sequence_generator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  prime_sequence_generator_if.master        bus
);

  localparam int unsigned      SQ_W       = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MAX_CAND   = '1;
  localparam logic [WIDTH-1:0] FIRST_CAND = WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEST = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_div;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_prime;
  logic             r_busy;
  logic             r_done;

  state_t           w_next_state;
  logic [WIDTH-1:0] w_cand_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_out_prime_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [SQ_W-1:0]  w_div_sq;
  logic [WIDTH-1:0] w_div_safe;
  logic             w_is_prime;
  logic             w_divides;
  logic             w_at_max;
  logic             w_handshake;

  // Square compared at double width so it cannot overflow for any divisor.
  assign w_div_sq    = SQ_W'(r_div) * SQ_W'(r_div);
  assign w_is_prime  = w_div_sq > SQ_W'(r_cand);
  // Divisor is only zero outside TEST; keep the modulo well defined anyway.
  assign w_div_safe  = (r_div == '0) ? FIRST_CAND : r_div;
  assign w_divides   = (r_cand % w_div_safe) == '0;
  assign w_at_max    = (r_cand == MAX_CAND);
  assign w_handshake = r_out_valid & bus.out_ready;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cand      <= '0;
      r_div       <= '0;
      r_out_valid <= 1'b0;
      r_out_prime <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cand      <= w_cand_nxt;
      r_div       <= w_div_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_prime <= w_out_prime_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next_state = S_TEST;
      S_TEST: begin
        if (w_is_prime)     w_next_state = S_EMIT;
        else if (w_divides) w_next_state = w_at_max ? S_DONE : S_TEST;
      end
      S_EMIT: if (w_handshake) w_next_state = w_at_max ? S_DONE : S_TEST;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and output next values; busy/done follow the next state so
  // they are registered yet aligned with the state they describe.
  always_comb begin
    w_cand_nxt      = r_cand;
    w_div_nxt       = r_div;
    w_out_valid_nxt = r_out_valid;
    w_out_prime_nxt = r_out_prime;
    w_busy_nxt      = (w_next_state == S_TEST) || (w_next_state == S_EMIT);
    w_done_nxt      = (w_next_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_cand_nxt = FIRST_CAND;
          w_div_nxt  = FIRST_CAND;
        end
      end
      S_TEST: begin
        if (w_is_prime) begin
          w_out_valid_nxt = 1'b1;
          w_out_prime_nxt = r_cand;
        end else if (w_divides) begin
          if (!w_at_max) begin
            w_cand_nxt = r_cand + WIDTH'(1);
            w_div_nxt  = FIRST_CAND;
          end
        end else begin
          w_div_nxt = r_div + WIDTH'(1);
        end
      end
      S_EMIT: begin
        if (w_handshake) begin
          w_out_valid_nxt = 1'b0;
          if (!w_at_max) begin
            w_cand_nxt = r_cand + WIDTH'(1);
            w_div_nxt  = FIRST_CAND;
          end
        end
      end
      default: w_out_valid_nxt = 1'b0;
    endcase
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_prime = r_out_prime;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_prime_sequence_generator.sv
// Purpose : self-checking bench for prime_sequence_generator at WIDTH=4 and
//           WIDTH=5; expected prime lists come from a brute-force primality
//           model, handshakes are collected and compared in order.
module tb_prime_sequence_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  int exp4[$];
  int exp5[$];
  int got4[$];
  int got5[$];
  bit timed_out;

  prime_sequence_generator_if #(.WIDTH(4)) if4 ();
  prime_sequence_generator_if #(.WIDTH(5)) if5 ();

  prime_sequence_generator #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  prime_sequence_generator #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));

  always #5 clk = ~clk;

  // Reference: n is prime if no d in 2..n-1 divides it.
  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d < n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Start a WIDTH=4 sweep and record every handshake until done is seen.
  task automatic collect4(input bit rand_ready, input bit spam_start);
    got4.delete();
    timed_out = 1'b1;
    if4.start = 1'b1;
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (if4.done) begin timed_out = 1'b0; break; end
      if (spam_start) if4.start = 1'($urandom_range(0, 1));
      if4.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (if4.out_valid && if4.out_ready) got4.push_back(int'(if4.out_prime));
      @(posedge clk); #1;
    end
    if4.start = 1'b0;
  endtask

  task automatic test_reset();
    if4.start = 1'b0; if4.out_ready = 1'b0;
    if5.start = 1'b0; if5.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (if4.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid4: got %0b expected 0", if4.out_valid); end
    tests_run++; if (if4.out_prime !== 4'd0) begin tests_failed++; $display("FAIL reset_prime4: got %0d expected 0", if4.out_prime); end
    tests_run++; if (if4.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy4: got %0b expected 0", if4.busy); end
    tests_run++; if (if4.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done4: got %0b expected 0", if4.done); end
    tests_run++; if (if5.out_valid !== 1'b0 || if5.out_prime !== 5'd0 || if5.busy !== 1'b0 || if5.done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outs5: got v=%0b p=%0d b=%0b d=%0b expected all 0", if5.out_valid, if5.out_prime, if5.busy, if5.done);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (if4.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_no_start_busy: got %0b expected 0", if4.busy); end
  endtask

  task automatic test_latency();
    tests_run++; if (if4.out_valid !== 1'b0 || if4.busy !== 1'b0) begin
      tests_failed++; $display("FAIL latency_pre: got v=%0b b=%0b expected 0 0", if4.out_valid, if4.busy);
    end
    if4.start = 1'b1; if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    tests_run++; if (if4.busy !== 1'b1 || if4.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL latency_edgeN: got b=%0b v=%0b expected 1 0", if4.busy, if4.out_valid);
    end
    @(posedge clk); #1;
    tests_run++; if (if4.out_valid !== 1'b1 || if4.out_prime !== 4'd2) begin
      tests_failed++; $display("FAIL latency_edgeN1: got v=%0b p=%0d expected 1 2", if4.out_valid, if4.out_prime);
    end
    timed_out = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (if4.done) begin timed_out = 1'b0; break; end
      @(posedge clk); #1;
    end
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL latency_drain_timeout: got 1 expected 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_sweep();
    collect4(1'b0, 1'b0);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL sweep4_timeout: got 1 expected 0"); end
    tests_run++; if (got4.size() !== exp4.size()) begin tests_failed++; $display("FAIL sweep4_count: got %0d expected %0d", got4.size(), exp4.size()); end
    foreach (exp4[i]) begin
      tests_run++;
      if (i >= got4.size() || got4[i] !== exp4[i]) begin
        tests_failed++; $display("FAIL sweep4_prime[%0d]: got %0d expected %0d", i, (i < got4.size()) ? got4[i] : -1, exp4[i]);
      end
    end
    @(posedge clk); #1;
    tests_run++; if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL sweep4_after_done: got d=%0b b=%0b v=%0b expected 0 0 0", if4.done, if4.busy, if4.out_valid);
    end
    tests_run++; if (int'(if4.out_prime) !== exp4[exp4.size()-1]) begin
      tests_failed++; $display("FAIL sweep4_last_held: got %0d expected %0d", if4.out_prime, exp4[exp4.size()-1]);
    end
  endtask

  task automatic test_backpressure();
    bit held = 1'b0;
    int idx5 = -1;
    got4.delete();
    if4.start = 1'b1; if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (if4.done) begin timed_out = 1'b0; break; end
      if (!held && if4.out_valid && if4.out_prime == 4'd5) begin
        held = 1'b1;
        if4.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          tests_run++; if (if4.out_valid !== 1'b1 || if4.out_prime !== 4'd5) begin
            tests_failed++; $display("FAIL stall_cycle%0d: got v=%0b p=%0d expected 1 5", k, if4.out_valid, if4.out_prime);
          end
        end
        if4.out_ready = 1'b1;
      end
      if (if4.out_valid && if4.out_ready) got4.push_back(int'(if4.out_prime));
      @(posedge clk); #1;
    end
    tests_run++; if (timed_out !== 1'b0 || held !== 1'b1) begin
      tests_failed++; $display("FAIL stall_reached: got timeout=%0b held=%0b expected 0 1", timed_out, held);
    end
    foreach (got4[i]) if (got4[i] == 5 && idx5 < 0) idx5 = i;
    tests_run++; if (idx5 < 0 || idx5 + 1 >= got4.size() || got4[idx5+1] !== 7) begin
      tests_failed++; $display("FAIL stall_next_is_7: got idx5=%0d size=%0d expected prime after 5 = 7", idx5, got4.size());
    end
    tests_run++; if (got4 != exp4) begin
      tests_failed++; $display("FAIL stall_sequence: got %0d primes (first %0d) expected %0d", got4.size(), (got4.size() > 0) ? got4[0] : -1, exp4.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 3; s++) begin
      collect4(1'b1, 1'b1);
      tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_timeout[%0d]: got 1 expected 0", s); end
      tests_run++; if (got4 != exp4) begin
        tests_failed++; $display("FAIL b2b_sequence[%0d]: got %0d primes (first %0d) expected %0d", s, got4.size(), (got4.size() > 0) ? got4[0] : -1, exp4.size());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    bit seen7 = 1'b0;
    if4.start = 1'b1; if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (if4.out_valid && if4.out_prime == 4'd7) begin seen7 = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests_run++; if (seen7 !== 1'b1) begin tests_failed++; $display("FAIL areset_reach7: got 0 expected 1"); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    tests_run++; if (if4.out_valid !== 1'b0 || if4.out_prime !== 4'd0 || if4.busy !== 1'b0 || if4.done !== 1'b0) begin
      tests_failed++; $display("FAIL areset_immediate: got v=%0b p=%0d b=%0b d=%0b expected all 0", if4.out_valid, if4.out_prime, if4.busy, if4.done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (if4.busy !== 1'b0) begin tests_failed++; $display("FAIL areset_idle: got %0b expected 0", if4.busy); end
    collect4(1'b0, 1'b0);
    tests_run++; if (got4.size() == 0 || got4[0] !== 2) begin
      tests_failed++; $display("FAIL areset_first_prime: got %0d expected 2", (got4.size() > 0) ? got4[0] : -1);
    end
    tests_run++; if (got4 != exp4) begin tests_failed++; $display("FAIL areset_sequence: got %0d primes expected %0d", got4.size(), exp4.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_width5();
    got5.delete();
    if5.start = 1'b1; if5.out_ready = 1'b1;
    @(posedge clk); #1;
    if5.start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (if5.done) begin timed_out = 1'b0; break; end
      if (if5.out_valid && if5.out_ready) got5.push_back(int'(if5.out_prime));
      @(posedge clk); #1;
    end
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL w5_timeout: got 1 expected 0"); end
    tests_run++; if (got5.size() !== 11) begin tests_failed++; $display("FAIL w5_count: got %0d expected 11", got5.size()); end
    tests_run++; if (got5 != exp5) begin tests_failed++; $display("FAIL w5_sequence: got %0d primes expected %0d", got5.size(), exp5.size()); end
    tests_run++; if (got5.size() == 0 || got5[got5.size()-1] !== 31) begin
      tests_failed++; $display("FAIL w5_last: got %0d expected 31", (got5.size() > 0) ? got5[got5.size()-1] : -1);
    end
    @(posedge clk); #1;
    tests_run++; if (if5.done !== 1'b0 || if5.busy !== 1'b0 || if5.out_prime !== 5'd31) begin
      tests_failed++; $display("FAIL w5_after_done: got d=%0b b=%0b p=%0d expected 0 0 31", if5.done, if5.busy, if5.out_prime);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 2; n <= 15; n++) if (is_prime(n)) exp4.push_back(n);
    for (int n = 2; n <= 31; n++) if (is_prime(n)) exp5.push_back(n);
    test_reset();
    test_latency();
    test_full_sweep();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_width5();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
